backprop_sequencer: RTL and testbench

- Controller that sequences one backprop_stack instance through a full backward pass.
- Per layer, it buffers the incoming backprop vectors, clears the layer's dy_dw, then replays the vectors to the stack in `size` back-to-back cycles and fires the cross-layer propagation.
- After the last layer, it walks the copy/dc_dw readout for every layer and flags each valid dc_dw_stream word.
- Sits between the upstream gradient producer (valid/ready) and backprop_stack.

---
 rtl/backprop_sequencer_if.sv | 21 ++
 rtl/backprop_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_backprop_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/backprop_sequencer_if.sv
// Producer-to-sequencer row bus: three backprop row vectors with a valid/ready handshake.
interface backprop_sequencer_if #(
  parameter int data_size = 8,
  parameter int size      = 3
) ();
  logic [data_size*size-1:0] in_start;
  logic [data_size*size-1:0] in_to_all;
  logic [data_size*size-1:0] in_dense;
  logic                      in_valid;
  logic                      in_ready;

  modport master (
    output in_start, in_to_all, in_dense, in_valid,
    input  in_ready
  );

  modport slave (
    input  in_start, in_to_all, in_dense, in_valid,
    output in_ready
  );
endinterface

// File: rtl/backprop_sequencer.sv
// Sequences one backprop_stack through a full backward pass: per-layer buffer/clear/replay,
// then a copy/dc_dw readout walk over every layer. All outputs are registered.
module backprop_sequencer #(
  parameter int data_size      = 8,
  parameter int size           = 3,
  parameter int max_layer_size = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [32:0]               num_layers,
  backprop_sequencer_if.slave       prod,
  output logic [data_size*size-1:0] bp_start,
  output logic [data_size*size-1:0] bp_to_all,
  output logic [data_size*size-1:0] bp_dense,
  output logic                      stack_clear,
  output logic                      copy,
  output logic                      cal_dy_dy_old,
  output logic [32:0]               current_layer_index,
  output logic [32:0]               dc_dw_layer_index,
  output logic                      dc_dw_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int VW = data_size * size;
  localparam int CW = $clog2(size + 1);
  localparam int LW = $clog2(max_layer_size + 1);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, PLAY, COPY, READ, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [LW-1:0]   n_q, n_d;
  logic            err_q, err_d;

  logic            in_ready_q, in_ready_d;
  logic            stack_clear_q, stack_clear_d;
  logic            copy_q, copy_d;
  logic            cal_q, cal_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dc_dw_valid_q, dc_dw_valid_d;
  logic [LW-1:0]   cur_idx_q, cur_idx_d;
  logic [CW-1:0]   dcw_idx_q, dcw_idx_d;
  logic            play_d;

  logic [LW-1:0]         layer_inc;
  logic                  legal_n;
  logic                  wr_en;
  logic [2:0][VW-1:0]    wr_word;
  logic [2:0][VW-1:0]    rd_word;
  logic [2:0][VW-1:0]    bp_word;
  logic [2:0][VW-1:0]    buf_mem [size];

  assign layer_inc = layer_q + LW'(1);
  assign legal_n   = (num_layers != 33'd0) && (num_layers <= 33'(max_layer_size));
  assign wr_word   = {prod.in_start, prod.in_to_all, prod.in_dense};

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    layer_d = layer_q;
    n_d     = n_q;
    err_d   = err_q;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal_n) begin
            n_d     = num_layers[LW-1:0];
            layer_d = '0;
            err_d   = 1'b0;
            state_d = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        fill_d  = '0;
        state_d = FILL;
      end
      FILL: begin
        if (prod.in_valid && in_ready_q) begin
          wr_en  = 1'b1;
          fill_d = fill_q + CW'(1);
          if (fill_q == LAST) begin
            cnt_d   = '0;
            state_d = PLAY;
          end
        end
      end
      PLAY: begin
        if (cnt_q == LAST) begin
          fill_d = '0;
          if (layer_inc < n_q) begin
            layer_d = layer_inc;
            state_d = CLEAR;
          end else begin
            // layer_q is reused as the readout layer K from here on
            layer_d = '0;
            state_d = COPY;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COPY: begin
        cnt_d   = '0;
        state_d = READ;
      end
      READ: begin
        if (cnt_q == LAST) begin
          if (layer_inc < n_q) begin
            layer_d = layer_inc;
            state_d = COPY;
          end else begin
            state_d = FLUSH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with state_q.
    play_d        = (state_d == PLAY);
    in_ready_d    = (state_d == FILL);
    stack_clear_d = (state_d == CLEAR);
    copy_d        = (state_d == COPY);
    done_d        = (state_d == FLUSH);
    busy_d        = (state_d != IDLE);
    cal_d         = play_d && (cnt_d == LAST) && (layer_d != '0);
    dc_dw_valid_d = (state_q == READ);
    cur_idx_d     = ((state_d == IDLE) || (state_d == FLUSH)) ? '0 : layer_d;
    dcw_idx_d     = (state_d == READ) ? cnt_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      fill_q        <= '0;
      cnt_q         <= '0;
      layer_q       <= '0;
      n_q           <= '0;
      err_q         <= 1'b0;
      in_ready_q    <= 1'b0;
      stack_clear_q <= 1'b0;
      copy_q        <= 1'b0;
      cal_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      dc_dw_valid_q <= 1'b0;
      cur_idx_q     <= '0;
      dcw_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      cnt_q         <= cnt_d;
      layer_q       <= layer_d;
      n_q           <= n_d;
      err_q         <= err_d;
      in_ready_q    <= in_ready_d;
      stack_clear_q <= stack_clear_d;
      copy_q        <= copy_d;
      cal_q         <= cal_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      dc_dw_valid_q <= dc_dw_valid_d;
      cur_idx_q     <= cur_idx_d;
      dcw_idx_q     <= dcw_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[fill_q] <= wr_word;
    end
  end

  // Bypass covers a row written in the same cycle it is first replayed (size of 1).
  assign rd_word = (wr_en && (fill_q == cnt_d)) ? wr_word : buf_mem[cnt_d];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_lane
      logic [VW-1:0] lane_q;
      always_ff @(posedge clk) begin
        if (!reset) begin
          lane_q <= '0;
        end else begin
          lane_q <= play_d ? rd_word[gi] : '0;
        end
      end
      assign bp_word[gi] = lane_q;
    end
  endgenerate

  assign bp_start            = bp_word[2];
  assign bp_to_all           = bp_word[1];
  assign bp_dense            = bp_word[0];
  assign prod.in_ready       = in_ready_q;
  assign stack_clear         = stack_clear_q;
  assign copy                = copy_q;
  assign cal_dy_dy_old       = cal_q;
  assign current_layer_index = 33'(cur_idx_q);
  assign dc_dw_layer_index   = 33'(dcw_idx_q);
  assign dc_dw_valid         = dc_dw_valid_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;
endmodule

// File: tb/tb_backprop_sequencer.sv
// Self-checking bench for backprop_sequencer: rows are pushed to a scoreboard when accepted
// and popped against bp_* on each replay beat; per-pass timing stats are checked per scenario.
module tb_backprop_sequencer;
  localparam int DS = 8;
  localparam int SZ = 3;
  localparam int ML = 4;
  localparam int VW = DS * SZ;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [32:0]   num_layers = '0;
  logic [VW-1:0] bp_start, bp_to_all, bp_dense;
  logic          stack_clear, copy, cal_dy_dy_old;
  logic [32:0]   current_layer_index, dc_dw_layer_index;
  logic          dc_dw_valid, busy, done, err;

  backprop_sequencer_if #(.data_size(DS), .size(SZ)) prod ();

  backprop_sequencer #(.data_size(DS), .size(SZ), .max_layer_size(ML)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .num_layers          (num_layers),
    .prod                (prod),
    .bp_start            (bp_start),
    .bp_to_all           (bp_to_all),
    .bp_dense            (bp_dense),
    .stack_clear         (stack_clear),
    .copy                (copy),
    .cal_dy_dy_old       (cal_dy_dy_old),
    .current_layer_index (current_layer_index),
    .dc_dw_layer_index   (dc_dw_layer_index),
    .dc_dw_valid         (dc_dw_valid),
    .busy                (busy),
    .done                (done),
    .err                 (err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscompares = 0;
  logic [3*VW-1:0] sb_q[$];

  int done_cyc, done_cnt, dv_cnt, clr_cnt, cal_cnt, max_idx;
  int clr_cyc[4];
  logic err_at1, busy_at1;

  function automatic logic [3*VW-1:0] make_row(input bit fixed, input int r);
    logic [7:0]  b;
    logic [95:0] t;
    b = 8'(r + 1);
    t = {$urandom(), $urandom(), $urandom()};
    if (fixed) return {(3*SZ){b}};
    return t[3*VW-1:0];
  endfunction

  // Runs one pass from a start pulse; optional per-layer stall after the second row,
  // a stray start pulse at a given cycle, or a reset at a given cycle.
  task automatic run_pass(input int n, input int stall_len, input int start_pulse_cyc,
                          input int reset_cyc, input bit fixed_rows);
    int cyc, acc, layer, play_left, stall_left, prev_cur, prev_dcw;
    bit aborted, v;
    logic [3*VW-1:0] row, exp_row;
    done_cyc = -1; done_cnt = 0; dv_cnt = 0; clr_cnt = 0; cal_cnt = 0; max_idx = 0;
    acc = 0; layer = 0; play_left = 0; stall_left = 0; prev_cur = 0; prev_dcw = 0;
    aborted = 1'b0;
    sb_q.delete();
    row = make_row(fixed_rows, 0);
    @(negedge clk);
    start = 1'b1;
    num_layers = 33'(n);
    prod.in_valid = 1'b1;
    {prod.in_start, prod.in_to_all, prod.in_dense} = row;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done_cnt == 0 && cyc < 400) begin
      if (aborted) begin
        vec_cnt++;
        if ({busy, done, stack_clear, prod.in_ready} !== 4'b0000) begin
          miscompares++;
          $display("FAIL reset_mid_play_ctrl cyc=%0d got busy/done/clr/rdy=%b want 0000", cyc,
                   {busy, done, stack_clear, prod.in_ready});
        end
        vec_cnt++;
        if ({bp_start, bp_to_all, bp_dense} !== '0) begin
          miscompares++;
          $display("FAIL reset_mid_play_bp got %h want 0", {bp_start, bp_to_all, bp_dense});
        end
        reset = 1'b1;
        break;
      end
      if (cyc == 1) begin
        err_at1 = err;
        busy_at1 = busy;
      end
      if (stack_clear) begin
        if (clr_cnt < 4) clr_cyc[clr_cnt] = cyc;
        clr_cnt++;
      end
      if (cal_dy_dy_old) cal_cnt++;
      if (int'(current_layer_index) > max_idx) max_idx = int'(current_layer_index);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dc_dw_valid) begin
        vec_cnt++;
        if (prev_dcw != dv_cnt % SZ || prev_cur != dv_cnt / SZ) begin
          miscompares++;
          $display("FAIL dc_dw_word %0d got layer=%0d idx=%0d want layer=%0d idx=%0d", dv_cnt,
                   prev_cur, prev_dcw, dv_cnt / SZ, dv_cnt % SZ);
        end
        dv_cnt++;
      end
      prev_cur = int'(current_layer_index);
      prev_dcw = int'(dc_dw_layer_index);
      if (play_left > 0) begin
        exp_row = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        vec_cnt++;
        if ({bp_start, bp_to_all, bp_dense} !== exp_row || cal_dy_dy_old !== (play_left == 1 && layer > 0)) begin
          miscompares++;
          $display("FAIL play_beat cyc=%0d layer=%0d got bp=%h cal=%b want bp=%h cal=%b", cyc, layer,
                   {bp_start, bp_to_all, bp_dense}, cal_dy_dy_old, exp_row, (play_left == 1 && layer > 0));
        end
        play_left--;
        if (play_left == 0) layer++;
      end else begin
        vec_cnt++;
        if ({bp_start, bp_to_all, bp_dense, cal_dy_dy_old} !== '0) begin
          miscompares++;
          $display("FAIL idle_bp cyc=%0d got bp=%h cal=%b want 0", cyc,
                   {bp_start, bp_to_all, bp_dense}, cal_dy_dy_old);
        end
      end
      // Producer drive for this cycle; acceptance happens at the coming posedge.
      v = (stall_left == 0);
      if (stall_left > 0) begin
        vec_cnt++;
        if (prod.in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_in_ready cyc=%0d got %b want 1", cyc, prod.in_ready);
        end
        stall_left--;
      end
      prod.in_valid = v;
      {prod.in_start, prod.in_to_all, prod.in_dense} = row;
      if (v && prod.in_ready === 1'b1) begin
        sb_q.push_back(row);
        acc++;
        if (acc == 2) stall_left = stall_len;
        if (acc == SZ) begin
          play_left = SZ;
          acc = 0;
        end
        row = make_row(fixed_rows, acc);
      end
      start = (cyc == start_pulse_cyc);
      if (cyc == start_pulse_cyc) num_layers = 33'd1;
      if (cyc == reset_cyc) begin
        reset = 1'b0;
        aborted = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    prod.in_valid = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      vec_cnt++;
      if (done_cnt == 0) begin
        miscompares++;
        $display("FAIL pass_timeout got no done within %0d cycles want done", cyc);
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        vec_cnt++;
        if ({busy, done} !== 2'b00) begin
          miscompares++;
          $display("FAIL post_done_idle +%0d got busy/done=%b want 00", i + 1, {busy, done});
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    prod.in_valid = 1'b0;
    {prod.in_start, prod.in_to_all, prod.in_dense} = '0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({busy, done, err, prod.in_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_status got busy/done/err/rdy=%b want 0000", {busy, done, err, prod.in_ready});
    end
    vec_cnt++;
    if ({stack_clear, copy, cal_dy_dy_old, dc_dw_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_pulses got %b want 0000", {stack_clear, copy, cal_dy_dy_old, dc_dw_valid});
    end
    vec_cnt++;
    if ({bp_start, bp_to_all, bp_dense, current_layer_index, dc_dw_layer_index} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got bp=%h cur=%0d dcw=%0d want 0", {bp_start, bp_to_all, bp_dense},
               current_layer_index, dc_dw_layer_index);
    end
    reset = 1'b1;
    @(negedge clk);
    $display("test_reset: outputs checked in reset");
  endtask

  task automatic test_basic();
    run_pass(2, 0, 0, 0, 1'b1);
    vec_cnt++;
    if (clr_cnt != 2 || clr_cyc[0] != 1 || clr_cyc[1] != 8) begin
      miscompares++;
      $display("FAIL basic_clear got cnt=%0d at %0d,%0d want 2 at 1,8", clr_cnt, clr_cyc[0], clr_cyc[1]);
    end
    vec_cnt++;
    if (done_cyc != 23) begin
      miscompares++;
      $display("FAIL basic_done_cycle got %0d want 23", done_cyc);
    end
    vec_cnt++;
    if (dv_cnt != 6) begin
      miscompares++;
      $display("FAIL basic_dc_dw_count got %0d want 6", dv_cnt);
    end
    vec_cnt++;
    if (cal_cnt != 1) begin
      miscompares++;
      $display("FAIL basic_cal_count got %0d want 1", cal_cnt);
    end
    vec_cnt++;
    if (max_idx != 1 || err_at1 !== 1'b0 || busy_at1 !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_misc got max_idx=%0d err=%b busy=%b want 1/0/1", max_idx, err_at1, busy_at1);
    end
    $display("test_basic: n=2 done at cycle %0d, %0d dc_dw words", done_cyc, dv_cnt);
  endtask

  task automatic test_stall();
    run_pass(2, 5, 0, 0, 1'b0);
    vec_cnt++;
    if (done_cyc != 33 || dv_cnt != 6) begin
      miscompares++;
      $display("FAIL stall_timing got done=%0d words=%0d want 33/6", done_cyc, dv_cnt);
    end
    $display("test_stall: n=2 with 5-cycle stall done at cycle %0d", done_cyc);
  endtask

  task automatic test_err();
    logic [32:0] bad[2];
    bad[0] = 33'd0;
    bad[1] = 33'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b1;
      num_layers = bad[i];
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      vec_cnt++;
      if ({err, busy} !== 2'b10) begin
        miscompares++;
        $display("FAIL err_illegal n=%0d got err/busy=%b want 10", bad[i], {err, busy});
      end
    end
    run_pass(1, 0, 0, 0, 1'b0);
    vec_cnt++;
    if (err_at1 !== 1'b0 || done_cyc != 12 || dv_cnt != 3 || cal_cnt != 0) begin
      miscompares++;
      $display("FAIL err_recover got err=%b done=%0d words=%0d cal=%0d want 0/12/3/0", err_at1,
               done_cyc, dv_cnt, cal_cnt);
    end
    $display("test_err: illegal starts flagged, n=1 pass done at cycle %0d", done_cyc);
  endtask

  task automatic test_start_busy();
    run_pass(2, 0, 17, 0, 1'b0);
    vec_cnt++;
    if (done_cnt != 1 || done_cyc != 23 || max_idx != 1) begin
      miscompares++;
      $display("FAIL start_busy got dones=%0d done=%0d max_idx=%0d want 1/23/1", done_cnt, done_cyc, max_idx);
    end
    $display("test_start_busy: stray start during readout ignored, done at cycle %0d", done_cyc);
  endtask

  task automatic test_reset_mid_play();
    run_pass(2, 0, 0, 13, 1'b1);
    vec_cnt++;
    if (done_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_no_done got %0d done pulses want 0", done_cnt);
    end
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_stays_idle got busy/done=%b want 00", {busy, done});
    end
    run_pass(2, 0, 0, 0, 1'b0);
    vec_cnt++;
    if (done_cyc != 23 || dv_cnt != 6) begin
      miscompares++;
      $display("FAIL reset_rerun got done=%0d words=%0d want 23/6", done_cyc, dv_cnt);
    end
    $display("test_reset_mid_play: abort then fresh pass done at cycle %0d", done_cyc);
  endtask

  initial begin
    prod.in_valid = 1'b0;
    {prod.in_start, prod.in_to_all, prod.in_dense} = '0;
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_start_busy();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
